// File: rtl/frame_buffer_manager_pkg.sv
// frame_buffer_manager_pkg: shared state encodings, buffer count and address defaults
package frame_buffer_manager_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_FIRST = 2'd1, RUN = 2'd2} mgr_state_t;
  typedef logic [1:0] buf_idx_t;
  localparam int NUM_BUF = 3;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h1000_0000;
  localparam logic [31:0] DEF_FRAME_STRIDE = 32'h0002_5800;
  function automatic buf_idx_t free_idx(input buf_idx_t a, input buf_idx_t b);
    return (a != 2'd0 && b != 2'd0) ? 2'd0 :
           (a != 2'd1 && b != 2'd1) ? 2'd1 : buf_idx_t'(NUM_BUF - 1);
  endfunction
endpackage

// File: rtl/frame_buffer_manager_edge_detect.sv
// edge_detect: one-cycle pulse on the first sample of d high after a low sample
module edge_detect (
  input  logic clk_100Mhz,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic q;
  always_ff @(posedge clk_100Mhz) q <= rst_n ? d : 1'b0;
  assign rise = d & ~q;
endmodule

// File: rtl/frame_buffer_manager.sv
// frame_buffer_manager: triple-buffer arbitration between a DDR frame writer and an HDMI reader
module frame_buffer_manager
  import frame_buffer_manager_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = DEF_BASE_ADDR,
  parameter logic [31:0] FRAME_STRIDE = DEF_FRAME_STRIDE,
  parameter int          CNT_W        = 16
) (
  input  logic             clk_100Mhz,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr_frame_done,
  input  logic             rd_vsync,
  output logic [31:0]      wr_base_addr,
  output logic [31:0]      rd_base_addr,
  output logic             rd_frame_valid,
  output logic [CNT_W-1:0] frames_written,
  output logic [CNT_W-1:0] frames_dropped,
  output logic [CNT_W-1:0] frames_repeated,
  output logic [1:0]       mgr_state
);
  mgr_state_t state, next_state;
  buf_idx_t wr_idx, rd_idx, lat_idx, nxt_wr, nxt_rd, nxt_lat;
  logic lat_valid, consumed, wr_rise, rd_rise;
  logic hold, wr_go, rd_go, take, drop, rep;
  function automatic logic [31:0] buf_addr(input buf_idx_t idx);
    return BASE_ADDR + {30'd0, idx} * FRAME_STRIDE;
  endfunction
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    return c + CNT_W'(inc && !(&c));
  endfunction
  edge_detect u_wr_edge (.clk_100Mhz(clk_100Mhz), .rst_n(rst_n), .d(wr_frame_done), .rise(wr_rise));
  edge_detect u_rd_edge (.clk_100Mhz(clk_100Mhz), .rst_n(rst_n), .d(rd_vsync), .rise(rd_rise));
  always_ff @(posedge clk_100Mhz) state <= rst_n ? next_state : IDLE;
  always_comb
    next_state = !en ? IDLE :
                 state == IDLE ? WAIT_FIRST :
                 (state == WAIT_FIRST && wr_rise) ? RUN : state;
  always_comb mgr_state = state;
  // Writer completion is applied first, so a coincident reader edge takes the fresh buffer.
  assign hold    = !en || state == IDLE;
  assign wr_go   = wr_rise && !hold;
  assign rd_go   = rd_rise && !hold && state == RUN;
  assign nxt_lat = wr_go ? wr_idx : lat_idx;
  assign take    = rd_go && (wr_go || (lat_valid && !consumed));
  assign nxt_rd  = hold ? 2'd1 : take ? nxt_lat : rd_idx;
  assign nxt_wr  = hold ? 2'd0 : wr_go ? free_idx(nxt_lat, nxt_rd) : wr_idx;
  assign drop    = wr_go && !rd_go && lat_valid && !consumed;
  assign rep     = rd_go && !take;
  always_ff @(posedge clk_100Mhz) begin
    if (!rst_n) begin
      wr_idx          <= 2'd0;
      rd_idx          <= 2'd1;
      lat_idx         <= 2'd0;
      lat_valid       <= 1'b0;
      consumed        <= 1'b1;
      wr_base_addr    <= BASE_ADDR;
      rd_base_addr    <= BASE_ADDR + FRAME_STRIDE;
      rd_frame_valid  <= 1'b0;
      frames_written  <= '0;
      frames_dropped  <= '0;
      frames_repeated <= '0;
    end else begin
      wr_idx          <= nxt_wr;
      rd_idx          <= nxt_rd;
      lat_idx         <= nxt_lat;
      lat_valid       <= !hold && (lat_valid || wr_go);
      consumed        <= hold || take || (consumed && !wr_go);
      wr_base_addr    <= buf_addr(nxt_wr);
      rd_base_addr    <= buf_addr(nxt_rd);
      rd_frame_valid  <= !hold && (rd_frame_valid || take);
      frames_written  <= sat_inc(frames_written, wr_go);
      frames_dropped  <= sat_inc(frames_dropped, drop);
      frames_repeated <= sat_inc(frames_repeated, rep);
    end
  end
endmodule

// File: tb/tb_frame_buffer_manager.sv
// tb_frame_buffer_manager: directed vectors with hand-computed expectations for frame_buffer_manager
module tb_frame_buffer_manager;
  logic clk_100Mhz = 1'b0;
  logic rst_n, en, wr_frame_done, rd_vsync;
  logic [31:0] wr_base_addr, rd_base_addr;
  logic rd_frame_valid;
  logic [15:0] frames_written, frames_dropped, frames_repeated;
  logic [1:0] mgr_state;
  int checks = 0;
  int failures = 0;
  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h1002_5800;
  localparam logic [31:0] A2 = 32'h1004_B000;
  frame_buffer_manager dut (
    .clk_100Mhz(clk_100Mhz), .rst_n(rst_n), .en(en),
    .wr_frame_done(wr_frame_done), .rd_vsync(rd_vsync),
    .wr_base_addr(wr_base_addr), .rd_base_addr(rd_base_addr),
    .rd_frame_valid(rd_frame_valid), .frames_written(frames_written),
    .frames_dropped(frames_dropped), .frames_repeated(frames_repeated),
    .mgr_state(mgr_state)
  );
  always #5 clk_100Mhz = ~clk_100Mhz;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_100Mhz);
    #1;
  endtask
  task automatic pulse(input logic w, input logic r);
    wr_frame_done = w;
    rd_vsync = r;
    tick();
    wr_frame_done = 1'b0;
    rd_vsync = 1'b0;
  endtask
  task automatic chk_counts(input string tag, input int w, input int d, input int r);
    chk({tag, "_written"}, {16'd0, frames_written}, w);
    chk({tag, "_dropped"}, {16'd0, frames_dropped}, d);
    chk({tag, "_repeated"}, {16'd0, frames_repeated}, r);
  endtask
  initial begin
    rst_n = 1'b0; en = 1'b0; wr_frame_done = 1'b0; rd_vsync = 1'b0;
    tick(3);
    chk("rst_wr_base", wr_base_addr, A0);
    chk("rst_rd_base", rd_base_addr, A1);
    chk("rst_valid", {31'd0, rd_frame_valid}, 0);
    chk("rst_state", {30'd0, mgr_state}, 0);
    chk_counts("rst", 0, 0, 0);
    rst_n = 1'b1; en = 1'b1;
    tick();
    chk("en_state", {30'd0, mgr_state}, 1);
    chk("en_wr_base", wr_base_addr, A0);
    chk("en_rd_base", rd_base_addr, A1);
    chk("en_valid", {31'd0, rd_frame_valid}, 0);
    pulse(1'b0, 1'b1);
    tick();
    chk("wf_rd_ignored_base", rd_base_addr, A1);
    chk("wf_rd_ignored_rep", {16'd0, frames_repeated}, 0);
    chk("wf_rd_ignored_state", {30'd0, mgr_state}, 1);
    pulse(1'b1, 1'b0);
    chk("wr1_wr_base", wr_base_addr, A2);
    chk("wr1_state", {30'd0, mgr_state}, 2);
    chk("wr1_valid", {31'd0, rd_frame_valid}, 0);
    tick();
    pulse(1'b0, 1'b1);
    chk("rd1_rd_base", rd_base_addr, A0);
    chk("rd1_valid", {31'd0, rd_frame_valid}, 1);
    chk("rd1_written", {16'd0, frames_written}, 1);
    tick();
    pulse(1'b0, 1'b1);
    chk("rd2_rd_base", rd_base_addr, A0);
    chk_counts("rd2", 1, 0, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst2_state", {30'd0, mgr_state}, 1);
    chk_counts("rst2", 0, 0, 0);
    pulse(1'b1, 1'b0);
    tick();
    chk("b1_wr_base", wr_base_addr, A2);
    chk("b1_ne", {31'd0, wr_base_addr != rd_base_addr}, 1);
    pulse(1'b1, 1'b0);
    tick();
    chk("b2_wr_base", wr_base_addr, A0);
    chk("b2_ne", {31'd0, wr_base_addr != rd_base_addr}, 1);
    wr_frame_done = 1'b1;
    tick(3);
    wr_frame_done = 1'b0;
    tick();
    chk("b3_wr_base", wr_base_addr, A2);
    chk("b3_rd_base", rd_base_addr, A1);
    chk("b3_ne", {31'd0, wr_base_addr != rd_base_addr}, 1);
    chk_counts("b3", 3, 2, 0);
    pulse(1'b1, 1'b1);
    chk("sim_rd_base", rd_base_addr, A2);
    chk("sim_wr_base", wr_base_addr, A0);
    chk("sim_valid", {31'd0, rd_frame_valid}, 1);
    chk_counts("sim", 4, 2, 0);
    tick();
    pulse(1'b0, 1'b1);
    chk("rep_rd_base", rd_base_addr, A2);
    chk("rep_count", {16'd0, frames_repeated}, 1);
    en = 1'b0;
    tick();
    en = 1'b1;
    chk("dis_state", {30'd0, mgr_state}, 0);
    chk("dis_wr_base", wr_base_addr, A0);
    chk("dis_rd_base", rd_base_addr, A1);
    chk("dis_valid", {31'd0, rd_frame_valid}, 0);
    chk_counts("dis", 4, 2, 1);
    wr_frame_done = 1'b1;
    tick();
    wr_frame_done = 1'b0;
    chk("idle_wr_ignored", {16'd0, frames_written}, 4);
    chk("reen_state", {30'd0, mgr_state}, 1);
    wr_frame_done = 1'b1;
    rd_vsync = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wr_frame_done = 1'b0;
    rd_vsync = 1'b0;
    chk("rstp_state", {30'd0, mgr_state}, 0);
    chk("rstp_wr_base", wr_base_addr, A0);
    chk("rstp_rd_base", rd_base_addr, A1);
    chk_counts("rstp", 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
